// File: rtl/wb_uart_tx_if.sv
// Wishbone pipelined responder bus for the console UART: request, stall and ack.
interface wb_uart_tx_if;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic        stb;
  logic        stall;
  logic        ack;
  logic [31:0] rdata;

  modport master (output addr, wdata, we, stb, input stall, ack, rdata);
  modport slave  (input addr, wdata, we, stb, output stall, ack, rdata);
endinterface

// File: rtl/wb_uart_tx.sv
// Boot console UART transmitter: Wishbone-written bytes are buffered in a small
// FIFO and sent as 8N1 frames with a programmable bit period of DIVISOR+1 clocks.
module wb_uart_tx #(
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned RESET_DIV  = 434
) (
  input  logic          clk,
  input  logic          reset,
  wb_uart_tx_if.slave   bus,
  output logic          tx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, busy;
  logic          accept, push, pop;
  logic [15:0]   divisor, div_latched, timer;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          tx_next;
  logic [31:0]   status, read_mux;
  logic          unused_wdata;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign busy  = (state != IDLE);

  // Only TXDATA writes can stall, and only on the registered full flag.
  assign bus.stall = bus.stb & bus.we & (bus.addr == 2'd0) & full;
  assign accept    = bus.stb & ~bus.stall & ~reset;
  assign push      = accept & bus.we & (bus.addr == 2'd0);

  assign status       = {19'd0, 5'(count), 5'd0, busy, empty, full};
  assign unused_wdata = ^bus.wdata[31:16];

  always_comb begin
    read_mux = '0;
    case (bus.addr)
      2'd1:    read_mux = status;
      2'd2:    read_mux = {16'd0, divisor};
      default: read_mux = '0;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
      divisor   <= 16'(RESET_DIV);
    end else begin
      bus.ack   <= accept;
      bus.rdata <= (accept & ~bus.we) ? read_mux : '0;
      if (accept & bus.we & (bus.addr == 2'd2))
        divisor <= bus.wdata[15:0];
    end
  end

  // NOTE: FIFO storage has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (timer == '0) state_next = DATA;
      end
      DATA: begin
        tx_next = shift[0];
        if (timer == '0 && bit_cnt == 3'd7) state_next = STOP;
      end
      STOP: begin
        if (timer == '0) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A pop always starts a frame: load the byte and freeze the bit period for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx          <= 1'b1;
      timer       <= '0;
      div_latched <= '0;
      shift       <= '0;
      bit_cnt     <= '0;
    end else begin
      tx <= tx_next;
      if (pop) begin
        shift       <= mem[rd_ptr];
        div_latched <= divisor;
        timer       <= divisor;
        bit_cnt     <= '0;
      end else if (state != IDLE) begin
        if (timer == '0) begin
          timer <= div_latched;
          if (state == DATA) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end else begin
          timer <= timer - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Scoreboarded bench for wb_uart_tx: bus responses and serial frames are checked
// by independent monitors against expectations queued when stimulus is issued.
module tb_wb_uart_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx;

  wb_uart_tx_if bus ();

  wb_uart_tx #(.FIFO_DEPTH(4), .RESET_DIV(434)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    string       name;
    bit          chk;
    logic [31:0] data;
    int          cyc;
  } bus_exp_t;

  typedef struct {
    logic [7:0] b;
    int         div;
    bit         contig;
  } frame_t;

  bus_exp_t bus_q[$];
  frame_t   tx_q[$];

  // Bus monitor: each ack must arrive exactly one cycle after its acceptance.
  bus_exp_t mon_e;
  always @(negedge clk) begin
    if (bus.ack === 1'b1) begin
      if (bus_q.size() == 0) begin
        check("unexpected_ack", {31'd0, bus.ack}, 32'd0);
      end else begin
        mon_e = bus_q.pop_front();
        check({mon_e.name, "_ack_cycle"}, cyc, mon_e.cyc + 1);
        if (mon_e.chk) check(mon_e.name, bus.rdata, mon_e.data);
      end
    end else if (bus_q.size() > 0 && bus_q[0].cyc < cyc - 1) begin
      mon_e = bus_q.pop_front();
      check({mon_e.name, "_ack_missing"}, {31'd0, bus.ack}, 32'd1);
    end
  end

  // Line monitor: decodes each frame cycle by cycle against the expected byte and period.
  int     pos = -1;
  int     bit_len = 1;
  int     errs = 0;
  int     last_end = -10;
  int     idx;
  logic   expb;
  frame_t cur;
  always @(negedge clk) begin
    if (reset) begin
      pos = -1;
      tx_q.delete();
    end else begin
      if (pos < 0 && tx === 1'b0) begin
        if (tx_q.size() == 0) begin
          check("unexpected_frame", {31'd0, tx}, 32'd1);
        end else begin
          cur = tx_q.pop_front();
          bit_len = cur.div + 1;
          errs = 0;
          pos = 0;
          if (cur.contig) check("frame_gap", cyc, last_end + 1);
        end
      end
      if (pos >= 0) begin
        idx = pos / bit_len;
        if (idx == 0)      expb = 1'b0;
        else if (idx == 9) expb = 1'b1;
        else               expb = cur.b[idx-1];
        if (tx !== expb) errs++;
        pos++;
        if (pos == 10 * bit_len) begin
          check($sformatf("frame_%02h_bad_cycles", cur.b), errs, 32'd0);
          last_end = cyc;
          pos = -1;
        end
      end
    end
  end

  task automatic wb_issue(input string name, input logic [1:0] a, input logic w,
                          input logic [31:0] d, input bit chk, input logic [31:0] exp,
                          output int stalls);
    bus_exp_t e;
    bus.addr  = a;
    bus.we    = w;
    bus.wdata = d;
    bus.stb   = 1'b1;
    stalls    = 0;
    @(negedge clk);
    while (bus.stall !== 1'b0 && stalls < 2000) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 2000) begin
      check({name, "_stall_timeout"}, {31'd0, bus.stall}, 32'd0);
    end else begin
      e.name = name;
      e.chk  = chk;
      e.data = exp;
      e.cyc  = cyc;
      bus_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.stb = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    int s;
    wb_issue(name, a, 1'b0, 32'hDEAD_BEEF, 1'b1, exp, s);
  endtask

  task automatic wr(input string name, input logic [1:0] a, input logic [31:0] d);
    int s;
    wb_issue(name, a, 1'b1, d, 1'b0, 32'd0, s);
  endtask

  task automatic wr_tx(input logic [31:0] d, input int div, input bit contig, output int stalls);
    frame_t f;
    f.b = d[7:0];
    f.div = div;
    f.contig = contig;
    tx_q.push_back(f);
    wb_issue($sformatf("txdata_%02h", d[7:0]), 2'd0, 1'b1, d, 1'b0, 32'd0, stalls);
  endtask

  task automatic wait_tx_idle(input int budget);
    int n = 0;
    while ((tx_q.size() != 0 || pos >= 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("tx_drain_timeout", tx_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  logic [7:0] burst [6] = '{8'h55, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h96};

  initial begin
    int s;
    bus.stb   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_ack", {31'd0, bus.ack}, 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    reset = 1'b0;

    // Back-to-back reads of reset register state.
    rd("status_reset", 2'd1, 32'h0000_0002);
    rd("divisor_reset", 2'd2, 32'h0000_01B2);

    // Single frame at 4 clocks per bit; status observed before and after the pop.
    wr("divisor_3", 2'd2, 32'd3);
    wr_tx(32'h0000_01A5, 3, 1'b0, s);
    rd("status_after_push", 2'd1, 32'h0000_0100);
    rd("status_in_frame", 2'd1, 32'h0000_0006);
    wait_tx_idle(200);
    rd("status_after_frame", 2'd1, 32'h0000_0002);

    // Six writes with strobe held: the sixth stalls until the stop-bit pop of frame 0.
    for (int i = 0; i < 6; i++) begin
      wr_tx({24'h0, burst[i]}, 3, (i > 0), s);
      if (i == 4) check("burst_w4_stalls", s, 32'd0);
      if (i == 5) check("burst_w5_stalls", s, 32'd37);
    end
    rd("status_full", 2'd1, 32'h0000_0405);
    wait_tx_idle(600);

    // Divisor change mid-frame only affects the following frame.
    wr_tx(32'h0000_003C, 3, 1'b0, s);
    wr_tx(32'h0000_00C3, 7, 1'b1, s);
    repeat (10) @(posedge clk);
    #1;
    wr("divisor_7", 2'd2, 32'd7);
    rd("divisor_readback", 2'd2, 32'h0000_0007);
    wait_tx_idle(400);

    // Unmapped and read-only addresses.
    rd("unmapped_read", 2'd3, 32'h0000_0000);
    wr("status_write", 2'd1, 32'hFFFF_FFFF);
    rd("txdata_read", 2'd0, 32'h0000_0000);
    rd("status_unchanged", 2'd1, 32'h0000_0002);
    wr("unmapped_write", 2'd3, 32'h0000_0055);
    rd("divisor_unchanged", 2'd2, 32'h0000_0007);

    // Reset in the middle of a frame with three bytes still queued.
    wr_tx(32'h0000_0011, 7, 1'b0, s);
    wr_tx(32'h0000_0022, 7, 1'b1, s);
    wr_tx(32'h0000_0033, 7, 1'b1, s);
    wr_tx(32'h0000_0044, 7, 1'b1, s);
    repeat (12) @(posedge clk);
    #1;
    reset    = 1'b1;
    bus.stb  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 2'd1;
    @(posedge clk);
    #1;
    check("reset_mid_frame_tx", {31'd0, tx}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_ack", {31'd0, bus.ack}, 32'd0);
    reset   = 1'b0;
    bus.stb = 1'b0;
    rd("status_after_reset", 2'd1, 32'h0000_0002);
    rd("divisor_after_reset", 2'd2, 32'h0000_01B2);
    repeat (400) @(posedge clk);
    #1;
    check("tx_idle_after_reset", {31'd0, tx}, 32'd1);

    check("bus_pending", bus_q.size(), 32'd0);
    check("frames_pending", tx_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
